// File: rtl/jts16_tile_sdram_resp_pkg.sv
// Shared constants for the tilemap SDRAM responder.
// Client indices, FSM states and handshake widths.
package jts16_tile_resp_pkg;

  localparam int NCL   = 5;
  localparam int DW    = 32;
  localparam int ACK_W = 1;
  localparam int RDY_W = 1;

  localparam int CL_CHAR = 0;
  localparam int CL_MAP1 = 1;
  localparam int CL_SCR1 = 2;
  localparam int CL_MAP2 = 3;
  localparam int CL_SCR2 = 4;

  typedef logic [2:0] cl_t;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT
  } st_t;

  function automatic logic [15:0] half_sel(
    input logic [DW-1:0] w,
    input logic          hi
  );
    return hi ? w[31:16] : w[15:0];
  endfunction

endpackage

// File: rtl/jts16_tile_sdram_resp_if.sv
// SDRAM bank read port seen by the tile responder.
// master issues addr/req, slave returns ack/rdy/din.
interface jts16_tile_sdram_resp_if #(
  parameter int AW = 22
);
  import jts16_tile_resp_pkg::*;

  logic [AW-1:0]    addr;
  logic             req;
  logic [ACK_W-1:0] ack;
  logic [RDY_W-1:0] rdy;
  logic [DW-1:0]    din;

  modport master (
    output addr, req,
    input  ack, rdy, din
  );

  modport slave (
    input  addr, req,
    output ack, rdy, din
  );

endinterface

// File: rtl/jts16_tile_sdram_resp_slot.sv
// One cached 32-bit word per client.
// hit is combinational on the live tag.
module jts16_tile_slot
  import jts16_tile_resp_pkg::*;
#(
  parameter int TW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [TW-1:0] cur_tag,
  input  logic          wr_en,
  input  logic [TW-1:0] wr_tag,
  input  logic [DW-1:0] wr_data,
  output logic [DW-1:0] word,
  output logic          hit
);

  logic [TW-1:0] tag_q;
  logic          vld_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      tag_q <= '0;
      word  <= '0;
      vld_q <= 1'b0;
    end else if (wr_en) begin
      tag_q <= wr_tag;
      word  <= wr_data;
      vld_q <= 1'b1;
    end
  end

  assign hit = vld_q && (tag_q == cur_tag);

endmodule

// File: rtl/jts16_tile_sdram_resp.sv
// Round-robin SDRAM responder for the five tilemap read clients.
// One outstanding read; each client keeps its last fetched word.
module jts16_tile_sdram_resp
  import jts16_tile_resp_pkg::*;
#(
  parameter int          AW          = 22,
  parameter logic [AW-1:0] CHAR_OFFSET = '0,
  parameter logic [AW-1:0] MAP1_OFFSET = '0,
  parameter logic [AW-1:0] SCR1_OFFSET = '0,
  parameter logic [AW-1:0] MAP2_OFFSET = '0,
  parameter logic [AW-1:0] SCR2_OFFSET = '0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] char_addr,
  output logic [31:0] char_data,
  output logic        char_ok,
  input  logic [14:0] map1_addr,
  output logic [15:0] map1_data,
  output logic        map1_ok,
  input  logic [15:0] scr1_addr,
  output logic [31:0] scr1_data,
  output logic        scr1_ok,
  input  logic [14:0] map2_addr,
  output logic [15:0] map2_data,
  output logic        map2_ok,
  input  logic [15:0] scr2_addr,
  output logic [31:0] scr2_data,
  output logic        scr2_ok,
  jts16_tile_sdram_resp_if.master sdram
);

  logic [15:0]    ctag [NCL];
  logic [AW-1:0]  coff [NCL];
  logic [DW-1:0]  word [NCL];
  logic [NCL-1:0] hit;
  logic [NCL-1:0] wr_en;

  st_t           st_q,   st_nx;
  cl_t           gnt_q,  gnt_nx;
  cl_t           rr_q,   rr_nx;
  logic [15:0]   tag_q,  tag_nx;
  logic [AW-1:0] addr_q, addr_nx;
  logic          req_q,  req_nx;

  logic          found;
  cl_t           gnt_sel;
  logic [3:0]    idx;

  // map tags drop the half-word bit so both halves share a slot
  always_comb begin
    ctag[CL_CHAR] = {4'd0, char_addr};
    ctag[CL_MAP1] = {2'd0, map1_addr[14:1]};
    ctag[CL_SCR1] = scr1_addr;
    ctag[CL_MAP2] = {2'd0, map2_addr[14:1]};
    ctag[CL_SCR2] = scr2_addr;
    coff[CL_CHAR] = CHAR_OFFSET;
    coff[CL_MAP1] = MAP1_OFFSET;
    coff[CL_SCR1] = SCR1_OFFSET;
    coff[CL_MAP2] = MAP2_OFFSET;
    coff[CL_SCR2] = SCR2_OFFSET;
  end

  for (genvar i = 0; i < NCL; i++) begin : g_slot
    localparam int TW = (i == CL_CHAR) ? 12 :
      ((i == CL_MAP1) || (i == CL_MAP2)) ? 14 : 16;
    jts16_tile_slot #(.TW(TW)) u_slot (
      .clk     (clk),
      .rst     (rst),
      .cur_tag (ctag[i][TW-1:0]),
      .wr_en   (wr_en[i]),
      .wr_tag  (tag_q[TW-1:0]),
      .wr_data (sdram.din),
      .word    (word[i]),
      .hit     (hit[i])
    );
  end

  always_comb begin
    found   = 1'b0;
    gnt_sel = '0;
    idx     = '0;
    for (int k = 0; k < NCL; k++) begin
      idx = {1'b0, rr_q} + 4'(k);
      if (idx >= 4'(NCL)) idx = idx - 4'(NCL);
      if (!found && !hit[idx[2:0]]) begin
        found   = 1'b1;
        gnt_sel = idx[2:0];
      end
    end
  end

  always_comb begin
    wr_en = '0;
    if (st_q == WAIT && sdram.rdy[0]) wr_en[gnt_q] = 1'b1;
  end

  always_comb begin
    st_nx   = st_q;
    gnt_nx  = gnt_q;
    rr_nx   = rr_q;
    tag_nx  = tag_q;
    addr_nx = addr_q;
    req_nx  = req_q;
    unique case (st_q)
      IDLE: if (found) begin
        gnt_nx  = gnt_sel;
        tag_nx  = ctag[gnt_sel];
        addr_nx = coff[gnt_sel] + AW'({tag_nx, 1'b0});
        req_nx  = 1'b1;
        st_nx   = REQ;
      end
      REQ: if (sdram.ack[0]) begin
        req_nx = 1'b0;
        st_nx  = WAIT;
      end
      WAIT: if (sdram.rdy[0]) begin
        rr_nx = (gnt_q == cl_t'(NCL - 1)) ? '0 : gnt_q + 3'd1;
        st_nx = IDLE;
      end
      default: st_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q   <= IDLE;
      gnt_q  <= '0;
      rr_q   <= '0;
      tag_q  <= '0;
      addr_q <= '0;
      req_q  <= 1'b0;
    end else begin
      st_q   <= st_nx;
      gnt_q  <= gnt_nx;
      rr_q   <= rr_nx;
      tag_q  <= tag_nx;
      addr_q <= addr_nx;
      req_q  <= req_nx;
    end
  end

  assign sdram.addr = addr_q;
  assign sdram.req  = req_q;

  assign char_data = word[CL_CHAR];
  assign char_ok   = hit[CL_CHAR];
  assign map1_data = half_sel(word[CL_MAP1], map1_addr[0]);
  assign map1_ok   = hit[CL_MAP1];
  assign scr1_data = word[CL_SCR1];
  assign scr1_ok   = hit[CL_SCR1];
  assign map2_data = half_sel(word[CL_MAP2], map2_addr[0]);
  assign map2_ok   = hit[CL_MAP2];
  assign scr2_data = word[CL_SCR2];
  assign scr2_ok   = hit[CL_SCR2];

endmodule

// File: tb/tb_jts16_tile_sdram_resp.sv
// Directed bench for jts16_tile_sdram_resp with a
// transaction-level cache model checked every cycle.
module tb_jts16_tile_sdram_resp;

  localparam logic [21:0] OFF_CHAR = 22'h100000;
  localparam logic [21:0] OFF_MAP1 = 22'h200000;
  localparam logic [21:0] OFF_SCR1 = 22'h010000;
  localparam logic [21:0] OFF_MAP2 = 22'h210000;
  localparam logic [21:0] OFF_SCR2 = 22'h3FFF00;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] char_addr;
  logic [31:0] char_data;
  logic        char_ok;
  logic [14:0] map1_addr;
  logic [15:0] map1_data;
  logic        map1_ok;
  logic [15:0] scr1_addr;
  logic [31:0] scr1_data;
  logic        scr1_ok;
  logic [14:0] map2_addr;
  logic [15:0] map2_data;
  logic        map2_ok;
  logic [15:0] scr2_addr;
  logic [31:0] scr2_data;
  logic        scr2_ok;

  jts16_tile_sdram_resp_if #(.AW(22)) sdram ();

  jts16_tile_sdram_resp #(
    .AW          (22),
    .CHAR_OFFSET (OFF_CHAR),
    .MAP1_OFFSET (OFF_MAP1),
    .SCR1_OFFSET (OFF_SCR1),
    .MAP2_OFFSET (OFF_MAP2),
    .SCR2_OFFSET (OFF_SCR2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .char_addr (char_addr),
    .char_data (char_data),
    .char_ok   (char_ok),
    .map1_addr (map1_addr),
    .map1_data (map1_data),
    .map1_ok   (map1_ok),
    .scr1_addr (scr1_addr),
    .scr1_data (scr1_data),
    .scr1_ok   (scr1_ok),
    .map2_addr (map2_addr),
    .map2_data (map2_data),
    .map2_ok   (map2_ok),
    .scr2_addr (scr2_addr),
    .scr2_data (scr2_data),
    .scr2_ok   (scr2_ok),
    .sdram     (sdram)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ---- model: one cached line per client, one read in flight
  logic        m_valid [5];
  logic [15:0] m_line  [5];
  logic [31:0] m_word  [5];
  int          m_phase;
  int          m_cl;
  int          m_ptr;
  logic [15:0] m_tag;
  logic [21:0] m_addr;

  function automatic logic [15:0] cur_line(input int i);
    case (i)
      0:       return {4'h0, char_addr};
      1:       return {2'b0, map1_addr[14:1]};
      2:       return scr1_addr;
      3:       return {2'b0, map2_addr[14:1]};
      default: return scr2_addr;
    endcase
  endfunction

  function automatic logic [21:0] offs(input int i);
    case (i)
      0:       return OFF_CHAR;
      1:       return OFF_MAP1;
      2:       return OFF_SCR1;
      3:       return OFF_MAP2;
      default: return OFF_SCR2;
    endcase
  endfunction

  function automatic logic mhit(input int i);
    return m_valid[i] && (m_line[i] == cur_line(i));
  endfunction

  function automatic int pick();
    for (int k = 0; k < 5; k++)
      if (!mhit((m_ptr + k) % 5)) return (m_ptr + k) % 5;
    return -1;
  endfunction

  function automatic logic [31:0] mdata(input int i);
    logic [31:0] w;
    w = m_word[i];
    if (i == 1) return {16'h0, map1_addr[0] ? w[31:16] : w[15:0]};
    if (i == 3) return {16'h0, map2_addr[0] ? w[31:16] : w[15:0]};
    return w;
  endfunction

  function automatic logic adut_ok(input int i);
    case (i)
      0:       return char_ok;
      1:       return map1_ok;
      2:       return scr1_ok;
      3:       return map2_ok;
      default: return scr2_ok;
    endcase
  endfunction

  function automatic logic [31:0] adut_data(input int i);
    case (i)
      0:       return char_data;
      1:       return {16'h0, map1_data};
      2:       return scr1_data;
      3:       return {16'h0, map2_data};
      default: return scr2_data;
    endcase
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 5; i++) begin
        m_valid[i] <= 1'b0;
        m_word[i]  <= '0;
      end
      m_phase <= 0;
      m_ptr   <= 0;
      m_addr  <= '0;
    end else begin
      case (m_phase)
        0: if (pick() >= 0) begin
          m_phase <= 1;
          m_cl    <= pick();
          m_tag   <= cur_line(pick());
          m_addr  <= 22'(offs(pick()) + 22'({cur_line(pick()), 1'b0}));
        end
        1: if (sdram.ack[0]) m_phase <= 2;
        default: if (sdram.rdy[0]) begin
          m_valid[m_cl] <= 1'b1;
          m_line[m_cl]  <= m_tag;
          m_word[m_cl]  <= sdram.din;
          m_ptr         <= (m_cl + 1) % 5;
          m_phase       <= 0;
        end
      endcase
    end
  end

  // ---- compare process
  int   rises [5];
  logic ok_prev [5];
  int   req_rises = 0;
  logic req_prev = 1'b0;

  initial for (int i = 0; i < 5; i++) begin
    rises[i]   = 0;
    ok_prev[i] = 1'b0;
  end

  always @(negedge clk) begin
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("ok%0d", i), 32'(adut_ok(i)), 32'(mhit(i)));
      chk($sformatf("data%0d", i), adut_data(i), mdata(i));
      if (adut_ok(i) && !ok_prev[i]) rises[i] <= rises[i] + 1;
      ok_prev[i] <= adut_ok(i);
    end
    chk("req", 32'(sdram.req), 32'(m_phase == 1));
    chk("addr", 32'(sdram.addr), 32'(m_addr));
    if (sdram.req && !req_prev) req_rises <= req_rises + 1;
    req_prev <= sdram.req;
  end

  // ---- SDRAM side stimulus
  task automatic wait_req(output logic [21:0] a);
    int n;
    n = 0;
    while (!sdram.req && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("req_seen", 32'(sdram.req), 32'd1);
    a = sdram.addr;
  endtask

  task automatic do_ack(input int d);
    repeat (d - 1) begin @(posedge clk); #1; end
    sdram.ack = 1'b1;
    @(posedge clk); #1;
    sdram.ack = 1'b0;
  endtask

  task automatic do_rdy(input int d, input logic [31:0] v);
    repeat (d - 1) begin @(posedge clk); #1; end
    sdram.rdy = 1'b1;
    sdram.din = v;
    @(posedge clk); #1;
    sdram.rdy = 1'b0;
  endtask

  task automatic serve(input logic [31:0] v, output logic [21:0] a);
    wait_req(a);
    do_ack(1);
    do_rdy(1, v);
  endtask

  logic [21:0] a;
  logic [21:0] seen [5];
  int          r0 [5];
  int          q0;
  logic [21:0] exp_order [5];

  initial begin
    rst       = 1'b1;
    sdram.ack = 1'b0;
    sdram.rdy = 1'b0;
    sdram.din = '0;
    char_addr = 12'h010;
    map1_addr = 15'h0002;
    scr1_addr = 16'h0000;
    map2_addr = 15'h0000;
    scr2_addr = 16'h0000;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_char_ok", 32'(char_ok), 32'd0);
    chk("rst_req", 32'(sdram.req), 32'd0);
    chk("rst_addr", 32'(sdram.addr), 32'd0);
    rst = 1'b0;

    // 1: char fetch with slow ack/rdy
    wait_req(a);
    chk("t1_addr", 32'(a), 32'h0010_0020);
    do_ack(2);
    do_rdy(3, 32'hDEADBEEF);
    chk("t1_ok", 32'(char_ok), 32'd1);
    chk("t1_data", char_data, 32'hDEADBEEF);

    // 2: map1 halves, then fill the rest
    serve(32'h1234_5678, a);
    chk("t2_addr", 32'(a), 32'h0020_0002);
    chk("t2_lo", 32'(map1_data), 32'h5678);
    serve(32'h1111_1111, a);
    serve(32'h2222_2222, a);
    serve(32'h3333_3333, a);
    @(posedge clk); #1;
    q0 = req_rises;
    for (int k = 0; k < 6; k++) begin
      map1_addr = (k % 2 == 0) ? 15'h0003 : 15'h0002;
      #1;
      chk("t2_ok", 32'(map1_ok), 32'd1);
      chk("t2_half", 32'(map1_data),
          (k % 2 == 0) ? 32'h1234 : 32'h5678);
      @(posedge clk); #1;
    end
    chk("t2_noreq", 32'(req_rises - q0), 32'd0);

    // 3: all five miss at once
    for (int i = 0; i < 5; i++) r0[i] = rises[i];
    q0 = req_rises;
    char_addr = 12'h011;
    map1_addr = 15'h0010;
    scr1_addr = 16'h0200;
    map2_addr = 15'h0020;
    scr2_addr = 16'h0055;
    exp_order[0] = 22'h100022;
    exp_order[1] = 22'h200010;
    exp_order[2] = 22'h010400;
    exp_order[3] = 22'h210020;
    exp_order[4] = 22'h3FFFAA;
    for (int i = 0; i < 5; i++) begin
      serve(32'hA000_0000 + 32'(i), seen[i]);
      chk($sformatf("t3_order%0d", i), 32'(seen[i]),
          32'(exp_order[i]));
      chk($sformatf("t3_ok%0d", i), 32'(adut_ok(i)), 32'd1);
    end
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++)
      chk($sformatf("t3_rise%0d", i), 32'(rises[i] - r0[i]), 32'd1);
    chk("t3_nreq", 32'(req_rises - q0), 32'd5);

    // 4: scr2 address moves while its read is in flight
    scr2_addr = 16'h0100;
    wait_req(a);
    chk("t4_addr1", 32'(a), 32'h0000_0100);
    do_ack(1);
    scr2_addr = 16'h0101;
    do_rdy(2, 32'h0BAD_0BAD);
    chk("t4_stale_ok", 32'(scr2_ok), 32'd0);
    wait_req(a);
    chk("t4_addr2", 32'(a), 32'h0000_0102);
    do_ack(1);
    do_rdy(1, 32'h600D_F00D);
    chk("t4_ok", 32'(scr2_ok), 32'd1);
    chk("t4_data", scr2_data, 32'h600D_F00D);

    // 5: reset during WAIT, stale rdy, then a normal fetch
    char_addr = 12'h0AB;
    wait_req(a);
    do_ack(1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("t5_req", 32'(sdram.req), 32'd0);
    for (int i = 0; i < 5; i++)
      chk($sformatf("t5_ok%0d", i), 32'(adut_ok(i)), 32'd0);
    @(posedge clk); #1;
    sdram.rdy = 1'b1;
    sdram.din = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    sdram.rdy = 1'b0;
    chk("t5_stale", 32'(char_ok), 32'd0);
    chk("t5_data0", char_data, 32'd0);
    wait_req(a);
    chk("t5_addr", 32'(a), 32'h0010_0156);
    sdram.ack = 1'b1;
    sdram.rdy = 1'b1;
    sdram.din = 32'h5555_5555;
    @(posedge clk); #1;
    sdram.ack = 1'b0;
    sdram.rdy = 1'b0;
    do_rdy(1, 32'hCAFE_F00D);
    chk("t5_ok", 32'(char_ok), 32'd1);
    chk("t5_data", char_data, 32'hCAFE_F00D);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
